// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with thresholds, occupancy count and error pulses.
// Latency: standard mode data_out valid 1 cycle after the accepting read edge; FWFT shows head word 1 cycle after the write into empty.
// Backpressure: writes are dropped while full (overflow pulse), reads dropped while empty (underflow pulse); no stall propagated.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   write_en, data_in write request and write data
//   read_en           read request (pop/acknowledge in FWFT mode)
//   data_out          read data (registered in standard mode, head-of-queue in FWFT mode)
//   full, empty       occupancy == DEPTH / occupancy == 0
//   almost_full       occupancy >= AF_LEVEL
//   almost_empty      occupancy <= AE_LEVEL
//   count             occupancy 0..DEPTH
//   overflow          one-cycle pulse after a write was rejected
//   underflow         one-cycle pulse after a read was rejected

module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int PTR_WIDTH = 6,
    parameter int AF_LEVEL  = (1 << PTR_WIDTH) - 4,
    parameter int AE_LEVEL  = 4,
    parameter bit FWFT      = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 write_en,
    input  logic                 read_en,
    input  logic [WIDTH-1:0]     data_in,
    output logic [WIDTH-1:0]     data_out,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [PTR_WIDTH:0]   count,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int DEPTH = 1 << PTR_WIDTH;

    typedef logic [PTR_WIDTH-1:0] ptr_t;
    typedef logic [PTR_WIDTH:0]   cnt_t;

    localparam cnt_t CNT_FULL = cnt_t'(DEPTH);
    localparam cnt_t AF_CNT   = cnt_t'(AF_LEVEL);
    localparam cnt_t AE_CNT   = cnt_t'(AE_LEVEL);

    // Storage is deliberately left out of reset; the pointers and count
    // define which entries are meaningful.
    logic [WIDTH-1:0] mem [DEPTH];

    ptr_t write_ptr;
    ptr_t read_ptr;
    cnt_t count_q;
    logic wr_ok;
    logic rd_ok;

    // Acceptance uses the registered flags only, so there is no
    // combinational path from the requests to any flag output.
    assign wr_ok = write_en & ~full;
    assign rd_ok = read_en  & ~empty;

    assign full         = (count_q == CNT_FULL);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_CNT);
    assign almost_empty = (count_q <= AE_CNT);
    assign count        = count_q;

    // Pointers wrap naturally at PTR_WIDTH bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            write_ptr <= '0;
            read_ptr  <= '0;
        end else begin
            if (wr_ok) begin
                write_ptr <= write_ptr + ptr_t'(1);
            end
            if (rd_ok) begin
                read_ptr <= read_ptr + ptr_t'(1);
            end
        end
    end

    // Acceptance is already gated by full/empty, so count stays in 0..DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            case ({wr_ok, rd_ok})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // One pulse per rejected request, reported the cycle after the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= write_en & full;
            underflow <= read_en & empty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[write_ptr] <= data_in;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head of queue is shown directly; a write into an empty FIFO
            // becomes visible together with empty falling, one cycle later.
            assign data_out = empty ? '0 : mem[read_ptr];
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_q <= '0;
                end else if (rd_ok) begin
                    dout_q <= mem[read_ptr];
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one standard-mode and one FWFT-mode instance,
// DEPTH=8, AF_LEVEL=6, AE_LEVEL=1, driven by directed steps with a queue
// scoreboard for the expected read data.

module tb_sync_fifo_param;

    logic       clk;
    // standard-mode instance
    logic       s_rst, s_we, s_re;
    logic [7:0] s_din, s_dout;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
    logic [3:0] s_cnt;
    // FWFT instance
    logic       f_rst, f_we, f_re;
    logic [7:0] f_din, f_dout;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
    logic [3:0] f_cnt;

    int tests = 0;
    int fails = 0;

    // reference model state for the standard instance
    logic [7:0] sbq[$];
    int         mcount = 0;
    logic [7:0] exp_dout = 8'h00;
    // reference queue for the FWFT instance
    logic [7:0] fq[$];

    sync_fifo_param #(.WIDTH(8), .PTR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1'b0)) u_std (
        .clk(clk), .rst(s_rst), .write_en(s_we), .read_en(s_re), .data_in(s_din),
        .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_cnt), .overflow(s_ovf), .underflow(s_udf)
    );

    sync_fifo_param #(.WIDTH(8), .PTR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst(f_rst), .write_en(f_we), .read_en(f_re), .data_in(f_din),
        .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_cnt), .overflow(f_ovf), .underflow(f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the standard instance, checked against the model.
    task automatic std_op(input logic we, input logic re, input logic [7:0] din, input string tag);
        logic wr_ok, rd_ok, e_ovf, e_udf;
        wr_ok = we && (mcount != 8);
        rd_ok = re && (mcount != 0);
        e_ovf = we && (mcount == 8);
        e_udf = re && (mcount == 0);
        if (rd_ok) exp_dout = sbq.pop_front();
        if (wr_ok) sbq.push_back(din);
        if (wr_ok && !rd_ok) mcount++;
        if (rd_ok && !wr_ok) mcount--;
        s_we  = we;
        s_re  = re;
        s_din = din;
        cyc();
        s_we = 1'b0;
        s_re = 1'b0;
        check({tag, ".count"}, 32'(s_cnt), 32'(mcount));
        check({tag, ".empty"}, 32'(s_empty), 32'(mcount == 0));
        check({tag, ".full"},  32'(s_full),  32'(mcount == 8));
        check({tag, ".af"},    32'(s_af),    32'(mcount >= 6));
        check({tag, ".ae"},    32'(s_ae),    32'(mcount <= 1));
        check({tag, ".ovf"},   32'(s_ovf),   32'(e_ovf));
        check({tag, ".udf"},   32'(s_udf),   32'(e_udf));
        check({tag, ".dout"},  32'(s_dout),  32'(exp_dout));
    endtask

    initial begin
        s_rst = 1'b0; s_we = 1'b0; s_re = 1'b0; s_din = 8'h00;
        f_rst = 1'b0; f_we = 1'b0; f_re = 1'b0; f_din = 8'h00;
        #2;
        check("rst.count", 32'(s_cnt), 32'd0);
        check("rst.empty", 32'(s_empty), 32'd1);
        check("rst.full", 32'(s_full), 32'd0);
        check("rst.ae", 32'(s_ae), 32'd1);
        check("rst.af", 32'(s_af), 32'd0);
        check("rst.dout", 32'(s_dout), 32'd0);
        check("rst.ovf", 32'(s_ovf), 32'd0);
        check("rst.udf", 32'(s_udf), 32'd0);
        check("rst.f_dout", 32'(f_dout), 32'd0);
        check("rst.f_empty", 32'(f_empty), 32'd1);
        cyc();
        s_rst = 1'b1;
        f_rst = 1'b1;
        cyc();

        // single word
        std_op(1'b1, 1'b0, 8'hA5, "single.wr");
        std_op(1'b0, 1'b1, 8'h00, "single.rd");

        // fill past full, then one idle cycle to see the overflow pulse end
        for (int i = 0; i < 9; i++) std_op(1'b1, 1'b0, 8'(i), $sformatf("fill%0d", i));
        std_op(1'b0, 1'b0, 8'h00, "fill.idle");

        // drain past empty; data_out must hold the last word
        for (int i = 0; i < 9; i++) std_op(1'b0, 1'b1, 8'h00, $sformatf("drain%0d", i));
        std_op(1'b0, 1'b0, 8'h00, "drain.idle");
        check("drain.hold", 32'(s_dout), 32'h07);

        // wrap: 3 resident words, then simultaneous write/read across the pointer wrap
        for (int i = 0; i < 3; i++) std_op(1'b1, 1'b0, 8'(8'h40 + i), $sformatf("pre%0d", i));
        for (int i = 0; i < 20; i++) std_op(1'b1, 1'b1, 8'(8'h50 + i), $sformatf("wrap%0d", i));
        for (int i = 0; i < 3; i++) std_op(1'b0, 1'b1, 8'h00, $sformatf("post%0d", i));

        // simultaneous requests at the empty and full boundaries
        std_op(1'b1, 1'b1, 8'h77, "both_empty");
        for (int i = 0; i < 7; i++) std_op(1'b1, 1'b0, 8'(8'h80 + i), $sformatf("refill%0d", i));
        std_op(1'b1, 1'b1, 8'h99, "both_full");
        for (int i = 0; i < 7; i++) std_op(1'b0, 1'b1, 8'h00, $sformatf("final%0d", i));

        // FWFT: word written into empty shows up before any read_en
        f_we = 1'b1; f_din = 8'h3C; fq.push_back(8'h3C);
        cyc();
        f_we = 1'b0;
        check("fwft.dout", 32'(f_dout), 32'(fq[0]));
        check("fwft.empty", 32'(f_empty), 32'd0);
        check("fwft.count", 32'(f_cnt), 32'd1);
        f_re = 1'b1; void'(fq.pop_front());
        cyc();
        f_re = 1'b0;
        check("fwft.pop_empty", 32'(f_empty), 32'd1);
        check("fwft.pop_dout", 32'(f_dout), 32'd0);

        for (int i = 0; i < 3; i++) begin
            f_we = 1'b1; f_din = 8'(8'h21 + i); fq.push_back(f_din);
            cyc();
        end
        f_we = 1'b0;
        check("fwft.head", 32'(f_dout), 32'(fq[0]));
        check("fwft.cnt3", 32'(f_cnt), 32'd3);

        // asynchronous reset in the middle of the cycle
        #3;
        f_rst = 1'b0;
        fq.delete();
        #1;
        check("mrst.count", 32'(f_cnt), 32'd0);
        check("mrst.empty", 32'(f_empty), 32'd1);
        check("mrst.dout", 32'(f_dout), 32'd0);
        check("mrst.ae", 32'(f_ae), 32'd1);
        #2;
        f_rst = 1'b1;
        cyc();
        f_we = 1'b1; f_din = 8'h11; fq.push_back(8'h11);
        cyc();
        f_we = 1'b0;
        check("mrst.first", 32'(f_dout), 32'(fq[0]));
        check("mrst.cnt1", 32'(f_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the fixed 64x8 FIFO.
- Generalises width and depth and adds:
  - programmable almost-full / almost-empty thresholds
  - occupancy count output
  - overflow / underflow error pulses
  - selectable standard or first-word-fall-through (FWFT) read mode
- Sits between a producer and a consumer in the same clock domain, e.g. buffering requests between master/slave handshake blocks.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- PTR_WIDTH, 6, address width; DEPTH = 1<<PTR_WIDTH entries.
- AF_LEVEL, DEPTH-4, almost_full asserts when count >= AF_LEVEL (1..DEPTH).
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1).
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- write_en  input  1  write request.
- read_en  input  1  read request.
- data_in  input  WIDTH  write data.
- data_out  output  WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  PTR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: a write was rejected.
- underflow  output  1  one-cycle pulse: a read was rejected.

Behaviour:
- Reset (rst low, asynchronous, takes effect immediately):
  - write_ptr = 0, read_ptr = 0, count = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - data_out = 0, overflow = 0, underflow = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data; the first read after reset returns the first post-reset write.
- Acceptance, evaluated on flag state before the edge:
  - wr_ok = write_en & ~full.
  - rd_ok = read_en & ~empty.
- Accepted write: mem[write_ptr] <= data_in; write_ptr increments modulo DEPTH (natural wrap of PTR_WIDTH bits).
- Accepted read: read_ptr increments modulo DEPTH.
- Count update:
  - wr_ok & ~rd_ok: count + 1.
  - rd_ok & ~wr_ok: count - 1.
  - both or neither: count unchanged.
  - count is never < 0 or > DEPTH.
- Simultaneous requests:
  - When empty, only the write is accepted and underflow pulses.
  - When full, only the read is accepted and overflow pulses.
  - When neither full nor empty, both are accepted.
- Flags:
  - full, empty, almost_full and almost_empty are decoded from the registered count.
  - They change the cycle after the accepting edge; there are no combinational paths from write_en/read_en.
- Error pulses:
  - overflow <= write_en & full; underflow <= read_en & empty.
  - Registered, high for exactly one cycle per rejected request.
  - Rejected requests do not change pointers, count or memory.
- Read data, FWFT = 0:
  - On rd_ok, data_out <= mem[read_ptr]; valid the cycle after the accepting edge (latency 1).
  - data_out holds its value when no read is accepted.
- Read data, FWFT = 1:
  - data_out continuously presents mem[read_ptr] while empty == 0; read_en acts as a pop/acknowledge.
  - When empty == 1, data_out is 0.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge, together with empty deasserting.
- Pointer wrap: after DEPTH accepted writes the write_ptr returns to 0; data ordering stays strictly FIFO across the wrap.

Test Plan (PTR_WIDTH=3, DEPTH=8, WIDTH=8, AF_LEVEL=6, AE_LEVEL=1):
- Reset and single word, FWFT=0: after reset, write 0xA5, then read.
  - Required: empty=1 and count=0 after reset.
  - Count=1 and empty=0 the cycle after the write.
  - data_out=0xA5 the cycle after the read edge; count=0 and empty=1.
- Fill and overflow: write 0x00..0x08 on 9 consecutive cycles with no reads.
  - almost_full rises when count reaches 6; full=1 at count=8.
  - 9th write rejected: overflow high for exactly 1 cycle; count stays 8.
- Drain and underflow: from full, read 9 consecutive cycles.
  - Data out in order 0x00..0x07; almost_empty=1 at count<=1; empty=1 at count=0.
  - 9th read rejected: underflow pulses once; data_out holds 0x07.
- Wrap-around: 20 cycles of simultaneous write (incrementing data) and read with 3 words resident.
  - count stays 3; output sequence is the input delayed by 3 accepted words across pointer wrap.
- Boundary simultaneity:
  - Write+read while empty: write accepted, underflow=1, count=1.
  - Write+read while full: read accepted, overflow=1, count=7.
- FWFT=1 and mid-operation reset:
  - Write 0x3C into empty FIFO: data_out=0x3C with empty=0 the next cycle, before any read_en.
  - Write 3 words, assert rst low mid-cycle: immediately count=0, empty=1, data_out=0.
  - After release, write 0x11: data_out=0x11.
